// File: rtl/psk_pkg.sv
// Shared definitions for the symbol upsampler: default sizing and the
// one-hot state encoding of the output sequencer.
package psk_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SPS   = 32;
  localparam int DEF_DEPTH = 4;

  // One-hot sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_RUN    = 3'b010,
    ST_STARVE = 3'b100
  } state_t;

endpackage

// File: rtl/sym_fifo.sv
// Synchronous symbol FIFO. Write side uses a valid/ready handshake with a
// registered ready; read side pops on rd_en when not empty (show-ahead data).
module sym_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_next_s;
  logic             ready_r;
  logic             push_s;
  logic             pop_s;

  assign push_s   = wr_valid & ready_r;
  assign pop_s    = rd_en & (count_r != {(AW + 1){1'b0}});
  assign empty    = (count_r == {(AW + 1){1'b0}});
  assign rd_data  = mem_r[rd_ptr_r];
  assign wr_ready = ready_r;

  // Occupancy after this cycle; push and pop together leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy and ready; ready is held low while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_next_s;
      ready_r <= (count_next_s < DEPTH_C);
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/symbol_upsampler.sv
// 1.024M-symbol to 32.768M-sample I/Q upsampler. Symbols are queued in a
// small FIFO and replayed for SPS clocks each, either held or zero-stuffed,
// with a one-cycle strobe on the first sample of every symbol.
module symbol_upsampler #(
  parameter int WIDTH = psk_pkg::DEF_WIDTH,
  parameter int SPS   = psk_pkg::DEF_SPS,
  parameter int DEPTH = psk_pkg::DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             HOLD_MODE,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I_1M,
  input  logic [WIDTH-1:0] Q_1M,
  output logic [WIDTH-1:0] I_32M,
  output logic [WIDTH-1:0] Q_32M,
  output logic             clk_out,
  output logic             underflow
);

  import psk_pkg::*;

  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t             state_r;
  state_t             state_next_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_next_s;
  logic [WIDTH-1:0]   sym_i_r;
  logic [WIDTH-1:0]   sym_q_r;
  logic               pop_s;
  logic               uf_set_s;
  logic               boundary_s;
  logic               fifo_empty_s;
  logic [2*WIDTH-1:0] fifo_data_s;
  logic [WIDTH-1:0]   i_next_s;
  logic [WIDTH-1:0]   q_next_s;
  logic               strobe_next_s;

  sym_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  ({I_1M, Q_1M}),
    .rd_en    (pop_s),
    .rd_data  (fifo_data_s),
    .empty    (fifo_empty_s)
  );

  assign boundary_s = (cnt_r == CNT_LAST);

  // Sequencer next state: symbol fetch, starvation and stop decisions
  // are only taken on the last phase of a symbol period.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    pop_s        = 1'b0;
    uf_set_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = {CW{1'b0}};
        if (en && !fifo_empty_s) begin
          pop_s        = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN, ST_STARVE: begin
        if (boundary_s) begin
          cnt_next_s = {CW{1'b0}};
          if (!en) begin
            state_next_s = ST_IDLE;
          end else if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_STARVE;
            uf_set_s     = (state_r == ST_RUN);
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // Next output sample: symbol on phase 0, then held value or zero.
  always_comb begin
    i_next_s      = {WIDTH{1'b0}};
    q_next_s      = {WIDTH{1'b0}};
    strobe_next_s = 1'b0;
    if (state_r == ST_RUN) begin
      if (cnt_r == {CW{1'b0}}) begin
        strobe_next_s = 1'b1;
        i_next_s      = sym_i_r;
        q_next_s      = sym_q_r;
      end else if (HOLD_MODE) begin
        i_next_s = sym_i_r;
        q_next_s = sym_q_r;
      end else begin
        i_next_s = {WIDTH{1'b0}};
        q_next_s = {WIDTH{1'b0}};
      end
    end else begin
      strobe_next_s = 1'b0;
    end
  end

  // Sequencer state, phase counter, current symbol and sticky underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      sym_i_r   <= {WIDTH{1'b0}};
      sym_q_r   <= {WIDTH{1'b0}};
      underflow <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (pop_s) {sym_i_r, sym_q_r} <= fifo_data_s;
      if (uf_set_s) underflow <= 1'b1;
    end
  end

  // Registered sample and strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      I_32M   <= {WIDTH{1'b0}};
      Q_32M   <= {WIDTH{1'b0}};
      clk_out <= 1'b0;
    end else begin
      I_32M   <= i_next_s;
      Q_32M   <= q_next_s;
      clk_out <= strobe_next_s;
    end
  end

endmodule

// File: tb/tb_symbol_upsampler.sv
// Self-checking bench for symbol_upsampler: a vector table for reset and
// first-symbol timing, directed corner sequences, and a randomized run,
// all compared every cycle against a queue-based reference model.
module tb_symbol_upsampler;

  localparam int W     = 16;
  localparam int SPS   = 32;
  localparam int DEPTH = 4;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STARVE = 2;

  logic         clk;
  logic         rst;
  logic         en;
  logic         HOLD_MODE;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] I_1M;
  logic [W-1:0] Q_1M;
  logic [W-1:0] I_32M;
  logic [W-1:0] Q_32M;
  logic         clk_out;
  logic         underflow;

  symbol_upsampler #(.WIDTH(W), .SPS(SPS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .HOLD_MODE (HOLD_MODE),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I_1M      (I_1M),
    .Q_1M      (Q_1M),
    .I_32M     (I_32M),
    .Q_32M     (Q_32M),
    .clk_out   (clk_out),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic [31:0] m_cur;
  int          m_mode;
  int          m_phase;
  logic        m_uf;
  logic        m_ready;
  logic [15:0] e_i;
  logic [15:0] e_q;
  logic        e_stb;

  task automatic model_step(input logic r, input logic e, input logic h,
                            input logic v, input logic [15:0] i, input logic [15:0] q);
    logic acc;
    logic last;
    if (r) begin
      m_q.delete();
      m_cur = 32'h0; m_mode = M_IDLE; m_phase = 0; m_uf = 1'b0; m_ready = 1'b0;
      e_i = 16'h0; e_q = 16'h0; e_stb = 1'b0;
    end else begin
      acc   = v && m_ready;
      e_stb = (m_mode == M_RUN) && (m_phase == 0);
      if (m_mode == M_RUN && (m_phase == 0 || h)) {e_i, e_q} = m_cur;
      else {e_i, e_q} = 32'h0;
      last = (m_phase == SPS - 1);
      if (m_mode == M_IDLE) begin
        if (e && m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_mode = M_RUN;
        end
        m_phase = 0;
      end else if (!last) begin
        m_phase++;
      end else begin
        m_phase = 0;
        if (!e) m_mode = M_IDLE;
        else if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_mode = M_RUN;
        end else begin
          if (m_mode == M_RUN) m_uf = 1'b1;
          m_mode = M_STARVE;
        end
      end
      if (acc) m_q.push_back({i, q});
      m_ready = (m_q.size() < DEPTH);
    end
  endtask

  // One clock: drive inputs, clock, advance model, compare all outputs.
  task automatic cycle(input logic r, input logic e, input logic h,
                       input logic v, input logic [15:0] i, input logic [15:0] q);
    rst = r; en = e; HOLD_MODE = h; in_valid = v; I_1M = i; Q_1M = q;
    @(posedge clk);
    model_step(r, e, h, v, i, q);
    #1;
    chk("model", 64'({I_32M, Q_32M, clk_out, underflow, in_ready}),
                 64'({e_i, e_q, e_stb, m_uf, m_ready}));
  endtask

  task automatic idle_cycle(input logic e, input logic h);
    cycle(1'b0, e, h, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic push(input logic e, input logic h, input logic [15:0] i, input logic [15:0] q);
    cycle(1'b0, e, h, 1'b1, i, q);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    idle_cycle(1'b0, 1'b1);
  endtask

  task automatic wait_strobe(input string name, input int bound, output int n);
    n = 0;
    do begin
      idle_cycle(1'b1, 1'b1);
      n++;
    end while (!clk_out && n < bound);
    chk(name, 64'(clk_out), 64'(1'b1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, en, hold, v;
    logic [15:0] i, q;
    logic [15:0] ei, eq;
    logic        estb, euf, erdy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic h, input logic v,
                              input logic [15:0] i, input logic [15:0] q,
                              input logic [15:0] ei, input logic [15:0] eq,
                              input logic es, input logic eu, input logic er);
    vec_t t;
    t.rst = r; t.en = e; t.hold = h; t.v = v; t.i = i; t.q = q;
    t.ei = ei; t.eq = eq; t.estb = es; t.euf = eu; t.erdy = er;
    return t;
  endfunction

  vec_t tbl[11];

  // Sequence: single symbol, expected shape derived directly from the rules.
  task automatic seq_single(input logic h);
    logic [15:0] exp_i;
    do_reset();
    push(1'b1, h, 16'h1234, 16'hEDCC);
    idle_cycle(1'b1, h);
    for (int k = 0; k <= 32; k++) begin
      idle_cycle(1'b1, h);
      exp_i = (k == 0 || (h && k < 32)) ? 16'h1234 : 16'h0000;
      chk("single_i", 64'(I_32M), 64'(exp_i));
      chk("single_stb", 64'(clk_out), 64'(k == 0));
    end
    chk("single_uf", 64'(underflow), 64'(1'b1));
  endtask

  logic [15:0] bsym[5];
  int          t_stb[$];
  logic [15:0] v_stb[$];
  int          n;
  int          hits;
  int          nstb;
  logic        dropped;
  logic        rr, re, rh, rv;
  int          rate;

  initial begin
    rst = 1'b1; en = 1'b0; HOLD_MODE = 1'b1; in_valid = 1'b0; I_1M = 16'h0; Q_1M = 16'h0;

    // Reset, first-symbol latency, hold-mode switching, mid-symbol reset.
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hEDCC, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'hEDCC, 1'b1, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'hEDCC, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'hEDCC, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].rst, tbl[k].en, tbl[k].hold, tbl[k].v, tbl[k].i, tbl[k].q);
      chk($sformatf("vec%0d", k), 64'({I_32M, Q_32M, clk_out, underflow, in_ready}),
          64'({tbl[k].ei, tbl[k].eq, tbl[k].estb, tbl[k].euf, tbl[k].erdy}));
    end

    // Single symbol, hold then zero-stuff.
    seq_single(1'b1);
    seq_single(1'b0);

    // Fill FIFO while stopped, overflow attempt, then drain in order.
    bsym[0] = 16'h1001; bsym[1] = 16'h2002; bsym[2] = 16'h3003;
    bsym[3] = 16'h4004; bsym[4] = 16'h5005;
    do_reset();
    for (int k = 0; k < 4; k++) push(1'b0, 1'b1, bsym[k], ~bsym[k]);
    chk("full_ready", 64'(in_ready), 64'(1'b0));
    push(1'b0, 1'b1, bsym[4], ~bsym[4]);
    chk("full_ready2", 64'(in_ready), 64'(1'b0));
    t_stb.delete(); v_stb.delete();
    for (int c = 0; c < 200; c++) begin
      idle_cycle(1'b1, 1'b1);
      if (clk_out) begin
        t_stb.push_back(c);
        v_stb.push_back(I_32M);
      end
    end
    chk("drain_nstb", 64'(t_stb.size()), 64'(4));
    for (int k = 0; k < t_stb.size() && k < 4; k++) begin
      chk("drain_order", 64'(v_stb[k]), 64'(bsym[k]));
      if (k > 0) chk("drain_spacing", 64'(t_stb[k] - t_stb[k-1]), 64'(SPS));
    end

    // Starvation and recovery on the next boundary.
    do_reset();
    push(1'b1, 1'b1, 16'h0A0A, 16'h0B0B);
    push(1'b1, 1'b1, 16'h0C0C, 16'h0D0D);
    n = 0;
    while (!underflow && n < 200) begin
      idle_cycle(1'b1, 1'b1);
      n++;
    end
    chk("starve_uf", 64'(underflow), 64'(1'b1));
    idle_cycle(1'b1, 1'b1);
    chk("starve_zero", 64'({I_32M, Q_32M, clk_out}), 64'(0));
    push(1'b1, 1'b1, 16'h7FFF, 16'h8000);
    wait_strobe("resume_stb", 64, n);
    chk("resume_gap", 64'(n), 64'(SPS - 1));
    chk("resume_i", 64'(I_32M), 64'(16'h7FFF));

    // Stop request mid-symbol: symbol completes, later symbols retained.
    do_reset();
    push(1'b0, 1'b1, 16'h1111, 16'h2222);
    push(1'b0, 1'b1, 16'h3333, 16'h4444);
    push(1'b0, 1'b1, 16'h5555, 16'h6666);
    wait_strobe("stop_first", 10, n);
    hits = (I_32M == 16'h1111) ? 1 : 0;
    nstb = 0;
    dropped = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (!dropped && m_phase == 10) dropped = 1'b1;
      idle_cycle(!dropped, 1'b1);
      if (I_32M == 16'h1111) hits++;
      if (clk_out) nstb++;
    end
    chk("stop_samples", 64'(hits), 64'(SPS));
    chk("stop_nstb", 64'(nstb), 64'(0));
    chk("stop_zero", 64'({I_32M, Q_32M}), 64'(0));
    wait_strobe("stop_restart", 10, n);
    chk("stop_next", 64'({I_32M, Q_32M}), 64'({16'h3333, 16'h4444}));

    // Reset mid-symbol with queued symbols.
    do_reset();
    for (int k = 0; k < 4; k++) push(1'b0, 1'b1, bsym[k], bsym[k] ^ 16'hFFFF);
    wait_strobe("rst_first", 10, n);
    n = 0;
    while (m_phase != 15 && n < 40) begin
      idle_cycle(1'b1, 1'b1);
      n++;
    end
    chk("rst_phase", 64'(m_phase), 64'(15));
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("rst_outs", 64'({I_32M, Q_32M, clk_out, underflow, in_ready}), 64'(0));
    nstb = 0;
    for (int c = 0; c < 70; c++) begin
      idle_cycle(1'b1, 1'b1);
      if (clk_out) nstb++;
    end
    chk("rst_nstb", 64'(nstb), 64'(0));
    push(1'b1, 1'b1, 16'hBEEF, 16'hCAFE);
    wait_strobe("rst_new", 10, n);
    chk("rst_new_i", 64'(I_32M), 64'(16'hBEEF));

    // Randomized traffic with varying source rate.
    do_reset();
    rh = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rate = (c < 1500) ? 40 : ((c < 2500) ? 8 : 60);
      rr = ($urandom_range(0, 599) == 0);
      re = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) rh = ~rh;
      rv = ($urandom_range(0, rate - 1) == 0);
      cycle(rr, re, rh, rv, 16'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
